// File: rtl/mem_stage_ctrl_if.sv
// Memory bus interface between the M-stage memory controller and the data memory.
//   mem_req   : bus request, driven from a register by the controller
//   mem_we    : write enable for the current request
//   mem_addr  : word address, bits [1:0] always zero
//   mem_wstrb : byte-lane write strobes
//   mem_wdata : store data, replicated across the lanes
//   mem_ack   : completion from memory, may arrive in the first request cycle
//   mem_rdata : read word, valid while mem_ack is high
// master modport: the controller. slave modport: the memory.
interface mem_stage_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wstrb,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wstrb,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// M-stage memory access controller.
// Accepts one load/store per access from the pipeline, checks alignment, runs a single
// request on the memory bus with an ack timeout, and returns aligned, extended load data
// for one cycle before going idle again.
// Ports:
//   clk, rst    : single clock, synchronous active-low reset
//   MemReadM    : load request          MemWriteM  : store request (wins if both set)
//   MemSizeM    : 00 byte, 01 half, 1x word
//   MemSignedM  : sign-extend byte/half loads
//   ALUResultM  : byte address          WriteDataM : right-justified store data
//   ReadDataM   : load result, non-zero only in the completion cycle
//   MemStallM   : stall request to the hazard unit
//   MisalignM   : one-cycle misaligned-access flag
//   BusErrM     : one-cycle bus timeout flag
//   bus         : memory bus, master side
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MemReadM,
  input  logic                   MemWriteM,
  input  logic [1:0]             MemSizeM,
  input  logic                   MemSignedM,
  input  logic [31:0]            ALUResultM,
  input  logic [31:0]            WriteDataM,
  output logic [31:0]            ReadDataM,
  output logic                   MemStallM,
  output logic                   MisalignM,
  output logic                   BusErrM,
  mem_stage_ctrl_if.master       bus
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // Counter value seen in the TIMEOUT-th request cycle.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic            we_q, we_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            buserr_q, buserr_d;

  logic        access;
  logic        aligned;
  logic        accept;
  logic        in_req;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Alignment check on the incoming pipeline access.
  always_comb begin
    access = MemReadM | MemWriteM;
    unique case (MemSizeM)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~ALUResultM[0];
      default: aligned = (ALUResultM[1:0] == 2'b00);
    endcase
    accept    = (state_q == StIdle) && access && aligned;
    MisalignM = (state_q == StIdle) && access && !aligned;
  end

  // Store lane placement, computed from the pipeline inputs at acceptance.
  always_comb begin
    unique case (MemSizeM)
      2'b00: begin
        st_wstrb = 4'b0001 << ALUResultM[1:0];
        st_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        st_wstrb = ALUResultM[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = WriteDataM;
      end
    endcase
    // Loads never strobe a lane.
    if (!MemWriteM) begin
      st_wstrb = 4'b0000;
    end
  end

  // Little-endian load lane extraction from the bus word, using the latched access.
  always_comb begin
    ld_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    unique case (size_q)
      2'b00:   ld_data = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{sgn_q & ld_half[15]}}, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    we_d     = we_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    buserr_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // mem_ack is ignored here; only a new aligned access moves the FSM.
        if (accept) begin
          addr_d  = ALUResultM;
          size_d  = MemSizeM;
          sgn_d   = MemSignedM;
          we_d    = MemWriteM;
          wstrb_d = st_wstrb;
          wdata_d = st_wdata;
          cnt_d   = '0;
          rdata_d = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.mem_ack) begin
          rdata_d = we_q ? 32'h0 : ld_data;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          rdata_d  = 32'h0;
          buserr_d = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        // Completion cycle; a pending access waits for the following idle cycle.
        rdata_d = 32'h0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= 32'h0;
      size_q   <= 2'b00;
      sgn_q    <= 1'b0;
      we_q     <= 1'b0;
      wstrb_q  <= 4'b0000;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      we_q     <= we_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
    end
  end

  // Outputs. Bus fields come straight from registers and are zero outside a request.
  always_comb begin
    in_req        = (state_q == StReq);
    MemStallM     = accept || in_req;
    ReadDataM     = (state_q == StDone) ? rdata_q : 32'h0;
    BusErrM       = buserr_q;
    bus.mem_req   = in_req;
    bus.mem_we    = in_req & we_q;
    bus.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    bus.mem_wstrb = in_req ? wstrb_q : 4'b0000;
    bus.mem_wdata = in_req ? wdata_q : 32'h0;
  end

endmodule
